// File: rtl/seg_pkg.sv
// Shared types, constants and the double-dabble step for the 4-digit 7-segment scan controller.
package seg_pkg;

    localparam int         DIGITS     = 4;
    localparam int         BIN_W      = 14;
    localparam int         WORK_W     = DIGITS * 4 + BIN_W;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [BIN_W-1:0] MAX_VALUE = 14'd9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift in the next operand MSB.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] t;
        t = w;
        for (int k = 0; k < DIGITS; k++) begin
            if (t[BIN_W + 4*k +: 4] >= 4'd5)
                t[BIN_W + 4*k +: 4] = t[BIN_W + 4*k +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter: accepted load -> busy for 15 cycles -> BCD register updates atomically.
// Loads arriving while busy are dropped; values above 9999 are clamped and flagged on ovf.
module bin_to_bcd
    import seg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  ovf,
    output logic [DIGITS*4-1:0]   bcd
);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        iter;
    logic [WORK_W-1:0] work;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (iter == 4'(BIN_W - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter <= '0;
            work <= '0;
            ovf  <= 1'b0;
            bcd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        work <= {{(DIGITS*4){1'b0}}, (value_in > MAX_VALUE) ? MAX_VALUE : value_in};
                        ovf  <= (value_in > MAX_VALUE);
                        iter <= '0;
                    end
                end
                SHIFT: begin
                    work <= dabble_step(work);
                    iter <= iter + 4'd1;
                end
                COMMIT:  bcd <= work[WORK_W-1:BIN_W];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment driver: converts a loaded value to BCD and scans one digit per REFRESH_DIV cycles.
// The scan never stalls; loads are ignored while the converter is busy.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] value_in,
    input  logic             load,
    input  logic             blank_lz,
    output logic             busy,
    output logic             ovf,
    output logic [3:0]       num,
    output logic [3:0]       an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [DIGITS*4-1:0] bcd;
    logic [CW-1:0]       rcnt;
    logic [1:0]          idx;
    logic [DIGITS-1:0]   zero_above;
    logic [3:0]          sel;

    bin_to_bcd u_bin_to_bcd (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .ovf      (ovf),
        .bcd      (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == CW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + CW'(1);
        end
    end

    // zero_above[k]: digits k..3 are all zero, so digit k is a leading zero.
    always_comb begin
        zero_above = '0;
        zero_above[DIGITS-1] = (bcd[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--)
            zero_above[k] = zero_above[k+1] && (bcd[4*k +: 4] == 4'd0);
    end

    always_comb begin
        sel = bcd[4*idx +: 4];
        num = sel;
        if (blank_lz && (idx != 2'd0) && zero_above[idx])
            num = BLANK_CODE;
    end

    assign an = ~(4'b0001 << idx);

endmodule
